// File: rtl/vga_capture_monitor_pkg.sv
// Shared constants, FSM state type and MISR/counter helpers for the VGA capture monitor.
package vga_capture_monitor_pkg;

    localparam int         DEF_H_DISPLAY   = 256;
    localparam int         DEF_H_BACK      = 23;
    localparam int         DEF_V_DISPLAY   = 240;
    localparam int         DEF_V_TOP       = 5;
    localparam logic       DEF_SYNC_ACTIVE = 1'b0;

    localparam logic [15:0] MISR_POLY = 16'h1021;
    localparam logic [15:0] MISR_SEED = 16'hFFFF;
    localparam logic [9:0]  CNT_MAX   = 10'd1023;

    typedef enum logic [1:0] {
        ST_SEEK    = 2'd0,
        ST_MEASURE = 2'd1,
        ST_LOCKED  = 2'd2
    } cap_state_e;

    function automatic logic [15:0] misr_step(input logic [15:0] sig, input logic [2:0] pix);
        return (sig << 1) ^ (sig[15] ? MISR_POLY : 16'h0000) ^ {13'b0, pix};
    endfunction

    function automatic logic [9:0] sat_inc(input logic [9:0] v);
        return (v == CNT_MAX) ? v : v + 10'd1;
    endfunction

endpackage

// File: rtl/vga_capture_monitor_sync_edge.sv
// One sync line: input register plus lead (becomes active) / trail (becomes inactive) detector.
module vga_sync_edge
    import vga_capture_monitor_pkg::*;
#(
    parameter logic ACTIVE = DEF_SYNC_ACTIVE
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_sync,
    output logic o_lead,
    output logic o_trail
);
    logic r_sync_q;
    logic r_active_d;
    logic w_active;

    assign w_active = (r_sync_q == ACTIVE);
    assign o_lead   = w_active & ~r_active_d;
    assign o_trail  = ~w_active & r_active_d;

    // Reset to the inactive level so release never fakes an edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync_q   <= ~ACTIVE;
            r_active_d <= 1'b0;
        end else begin
            r_sync_q   <= i_sync;
            r_active_d <= w_active;
        end
    end

endmodule

// File: rtl/vga_capture_monitor.sv
// VGA receive-side monitor: recovers timing, tracks lock, regenerates coordinates, signs each frame.
module vga_capture_monitor
    import vga_capture_monitor_pkg::*;
#(
    parameter int   H_DISPLAY   = DEF_H_DISPLAY,
    parameter int   H_BACK      = DEF_H_BACK,
    parameter int   V_DISPLAY   = DEF_V_DISPLAY,
    parameter int   V_TOP       = DEF_V_TOP,
    parameter logic SYNC_ACTIVE = DEF_SYNC_ACTIVE
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        hsync,
    input  logic        vsync,
    input  logic [2:0]  rgb,
    output logic        locked,
    output logic        pix_valid,
    output logic [9:0]  pix_x,
    output logic [9:0]  pix_y,
    output logic [2:0]  pix_rgb,
    output logic        frame_done,
    output logic [15:0] frame_sig,
    output logic [9:0]  h_total,
    output logic [9:0]  v_total,
    output logic [7:0]  err_count
);
    localparam logic [9:0] H_START = 10'(H_BACK);
    localparam logic [9:0] H_END   = 10'(H_BACK + H_DISPLAY);
    localparam logic [9:0] V_START = 10'(V_TOP);
    localparam logic [9:0] V_END   = 10'(V_TOP + V_DISPLAY);

    logic w_hs_lead, w_hs_trail, w_vs_lead, w_vs_trail;

    vga_sync_edge #(.ACTIVE(SYNC_ACTIVE)) u_hs_edge (
        .clk(clk), .rst_n(reset), .i_sync(hsync), .o_lead(w_hs_lead), .o_trail(w_hs_trail)
    );
    vga_sync_edge #(.ACTIVE(SYNC_ACTIVE)) u_vs_edge (
        .clk(clk), .rst_n(reset), .i_sync(vsync), .o_lead(w_vs_lead), .o_trail(w_vs_trail)
    );

    logic [2:0]  r_rgb_q;
    logic [9:0]  r_hcnt, r_hper, r_vcnt, r_vper;
    logic        r_hper_ok, r_vper_ok, r_vclr_pend;
    cap_state_e  r_state;
    logic [9:0]  r_h_ref, r_v_ref;
    logic        r_href_ok;
    logic [15:0] r_sig;
    logic        r_locked, r_pix_valid, r_frame_done;
    logic [9:0]  r_pix_x, r_pix_y, r_h_total, r_v_total;
    logic [2:0]  r_pix_rgb;
    logic [15:0] r_frame_sig;
    logic [7:0]  r_err_count;

    logic [9:0] w_hcnt_nxt, w_vcnt_nxt, w_line_len, w_lines_in_frame;
    logic       w_vclr, w_active, w_line_chk, w_hsat, w_lock_bad;

    // The _nxt values line up with the pixel currently held in r_rgb_q.
    assign w_hcnt_nxt       = w_hs_trail ? 10'd0 : sat_inc(r_hcnt);
    assign w_vclr           = w_hs_lead && (r_vclr_pend || w_vs_trail);
    assign w_vcnt_nxt       = w_vclr ? 10'd0 : (w_hs_lead ? sat_inc(r_vcnt) : r_vcnt);
    assign w_line_len       = sat_inc(r_hper);
    assign w_lines_in_frame = w_hs_lead ? sat_inc(r_vper) : r_vper;
    assign w_active         = (w_hcnt_nxt >= H_START) && (w_hcnt_nxt < H_END) &&
                              (w_vcnt_nxt >= V_START) && (w_vcnt_nxt < V_END);
    assign w_line_chk       = w_hs_lead && r_hper_ok;
    assign w_hsat           = (r_hper == CNT_MAX) || (w_hs_lead && w_line_len == CNT_MAX);
    assign w_lock_bad       = (w_line_chk && w_line_len != r_h_ref) || w_hsat ||
                              (w_vs_lead && w_lines_in_frame != r_v_ref);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rgb_q     <= 3'd0;
            r_hcnt      <= 10'd0;
            r_hper      <= 10'd0;
            r_vcnt      <= 10'd0;
            r_vper      <= 10'd0;
            r_hper_ok   <= 1'b0;
            r_vper_ok   <= 1'b0;
            r_vclr_pend <= 1'b0;
            r_pix_valid <= 1'b0;
            r_pix_x     <= 10'd0;
            r_pix_y     <= 10'd0;
            r_pix_rgb   <= 3'd0;
            r_sig       <= MISR_SEED;
        end else begin
            r_rgb_q     <= rgb;
            r_hcnt      <= w_hcnt_nxt;
            r_vcnt      <= w_vcnt_nxt;
            r_hper      <= w_hs_lead ? 10'd0 : w_line_len;
            r_vper      <= w_vs_lead ? 10'd0 : w_lines_in_frame;
            r_hper_ok   <= r_hper_ok | w_hs_lead;
            r_vper_ok   <= r_vper_ok | w_vs_lead;
            r_vclr_pend <= w_hs_lead ? 1'b0 : (r_vclr_pend | w_vs_trail);
            r_pix_valid <= r_locked && w_active;
            r_pix_rgb   <= r_rgb_q;
            if (w_active) begin
                r_pix_x <= w_hcnt_nxt - H_START;
                r_pix_y <= w_vcnt_nxt - V_START;
            end
            if (w_vs_trail)
                r_sig <= MISR_SEED;
            else if (r_pix_valid)
                r_sig <= misr_step(r_sig, r_pix_rgb);
        end
    end

    // Lock FSM; every output it drives is a register updated here.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= ST_SEEK;
            r_h_ref      <= 10'd0;
            r_v_ref      <= 10'd0;
            r_href_ok    <= 1'b0;
            r_locked     <= 1'b0;
            r_frame_done <= 1'b0;
            r_frame_sig  <= 16'd0;
            r_h_total    <= 10'd0;
            r_v_total    <= 10'd0;
            r_err_count  <= 8'd0;
        end else begin
            r_frame_done <= 1'b0;
            case (r_state)
                ST_SEEK: begin
                    r_locked  <= 1'b0;
                    r_h_ref   <= 10'd0;
                    r_v_ref   <= 10'd0;
                    r_href_ok <= 1'b0;
                    if (w_vs_trail)
                        r_state <= ST_MEASURE;
                end
                ST_MEASURE: begin
                    if (w_hsat || (w_line_chk && r_href_ok && w_line_len != r_h_ref)) begin
                        r_state <= ST_SEEK;
                    end else begin
                        if (w_line_chk && !r_href_ok) begin
                            r_h_ref   <= w_line_len;
                            r_href_ok <= 1'b1;
                        end
                        if (w_vs_lead) begin
                            if (!r_vper_ok || !r_href_ok || w_lines_in_frame == CNT_MAX) begin
                                r_state <= ST_SEEK;
                            end else begin
                                r_v_ref   <= w_lines_in_frame;
                                r_h_total <= r_h_ref;
                                r_v_total <= w_lines_in_frame;
                            end
                        end else if (w_vs_trail) begin
                            r_state  <= ST_LOCKED;
                            r_locked <= 1'b1;
                        end
                    end
                end
                ST_LOCKED: begin
                    if (w_lock_bad) begin
                        r_state  <= ST_SEEK;
                        r_locked <= 1'b0;
                        if (r_err_count != 8'hFF)
                            r_err_count <= r_err_count + 8'd1;
                    end else if (w_vs_lead) begin
                        r_frame_sig  <= r_sig;
                        r_frame_done <= 1'b1;
                    end
                end
                default: r_state <= ST_SEEK;
            endcase
        end
    end

    assign locked     = r_locked;
    assign pix_valid  = r_pix_valid;
    assign pix_x      = r_pix_x;
    assign pix_y      = r_pix_y;
    assign pix_rgb    = r_pix_rgb;
    assign frame_done = r_frame_done;
    assign frame_sig  = r_frame_sig;
    assign h_total    = r_h_total;
    assign v_total    = r_v_total;
    assign err_count  = r_err_count;

endmodule

// File: doc/vga_capture_monitor.md
Name: vga_capture_monitor

Overview:
- Receive end of the VGA pixel interface: consumes the hsync/vsync/rgb stream produced by the team's VGA generators and test patterns.
- Recovers line and frame timing and tracks sync lock.
- Regenerates pixel coordinates and produces a per-frame 16-bit MISR signature of the active-area pixels.
- Used in self-checking benches and on-chip loopback to verify display blocks without a monitor.

Parameters:
- H_DISPLAY, 256, active pixels per line.
- H_BACK, 23, cycles from the first sync-inactive cycle after hsync to pixel x=0.
- V_DISPLAY, 240, active lines per frame.
- V_TOP, 5, lines from the first line after vsync ends to line y=0.
- SYNC_ACTIVE, 0, asserted level of hsync/vsync (0 = active-low).

Ports:
- clk  in  1  pixel clock; all inputs are synchronous to it.
- reset  in  1  asynchronous, active-low reset.
- hsync  in  1  horizontal sync.
- vsync  in  1  vertical sync.
- rgb  in  3  pixel colour {b,g,r}.
- locked  out  1  timing is locked.
- pix_valid  out  1  pix_* fields hold an active-area pixel.
- pix_x  out  10  recovered x.
- pix_y  out  10  recovered y.
- pix_rgb  out  3  captured colour.
- frame_done  out  1  1-cycle pulse at the end of each locked frame.
- frame_sig  out  16  signature of the last completed locked frame.
- h_total  out  10  measured cycles per line.
- v_total  out  10  measured lines per frame.
- err_count  out  8  lock-loss count, saturating.

Behaviour:
- Reset (reset=0, asynchronous): all outputs 0, FSM in SEEK, counters 0, MISR = 16'hFFFF.
- Input register: hsync, vsync and rgb are registered once. All edge detection uses the registered copies; hs = (hsync_q==SYNC_ACTIVE), same for vs.
- Edges: hs_lead = hs rises; hs_trail = hs falls. vs_lead and vs_trail likewise.
- hcnt (10b): cleared on hs_trail, else increments, saturating at 1023.
- hper (10b): cycles between successive hs_lead, saturating at 1023. Sampled on each hs_lead as line_len.
- vcnt (10b): cleared on the first hs_lead after vs_trail, else increments on each hs_lead, saturating. lines_in_frame is sampled at vs_lead.
- Recovered coordinates: x = hcnt − H_BACK; y = vcnt − V_TOP. A value is active only when 0 ≤ x < H_DISPLAY and 0 ≤ y < V_DISPLAY (unsigned compare after range check).
- pix_valid = locked && active. pix_x, pix_y and pix_rgb are registered. Latency from rgb input to pix_rgb is exactly 2 cycles.
- FSM states: SEEK, MEASURE, LOCKED.
  - SEEK: on vs_trail → MEASURE; clear the reference values.
  - MEASURE: the first line_len is stored as h_ref. Any later line_len ≠ h_ref, or a saturated value → SEEK. On vs_lead, store v_ref = lines_in_frame and publish h_total/v_total. On the next vs_trail → LOCKED.
  - LOCKED: locked=1. A line_len ≠ h_ref, or at vs_lead lines_in_frame ≠ v_ref → SEEK, locked=0 on the next cycle, err_count += 1 (saturating at 255).
- MISR:
  - Seeded 16'hFFFF on vs_trail.
  - Each pix_valid cycle: sig ← (sig<<1) ^ (sig[15] ? 16'h1021 : 0) ^ {13'b0, pix_rgb}.
  - On vs_lead while LOCKED and no mismatch: frame_sig ← sig and frame_done pulses for 1 cycle.
  - On lock loss, frame_sig is held and frame_done is not pulsed.
- Simultaneous events:
  - hs_lead and vs_lead in the same cycle: the line is counted first, then the frame check runs.
  - hs_trail takes priority over saturation.
- A lock check never uses the partial first line after reset.
- Reset mid-frame: immediate return to SEEK. Relock requires one complete measured frame.

Decomposition:
- Shared package: the default timing constants (matching the generator), SYNC_ACTIVE, MISR_POLY=16'h1021, MISR_SEED=16'hFFFF, and the FSM state enum.
- One natural sub-module, vga_sync_edge: register plus edge detector for one sync line, outputting lead/trail. Instantiate it twice.

Test Plan:
- Generator model at defaults (309×262, active-low) → locked=1 one cycle after the 2nd vs_trail; h_total=309, v_total=262; err_count=0.
- Grid test pattern, locked → the first pix_valid has pix_x=0, pix_y=0, pix_rgb=3'b001; exactly 61440 pix_valid cycles per frame; frame_done once per frame.
- Constant rgb=0 for two locked frames → identical frame_sig both frames, matching the reference-model MISR value.
- One line stretched to 310 cycles in a locked frame → locked drops; err_count=1; no frame_done that frame; relock after 2 frames.
- reset pulsed low for 3 cycles mid-frame → all outputs 0 asynchronously; relock follows the normal sequence; err_count stays 0.
- hsync held inactive for 1100 cycles → hper saturates at 1023; FSM returns to SEEK; err_count increments once.
